switch_debounce_sync: RTL and testbench
=======================================

Name: switch_debounce_sync

Overview:
- Conditioning stage directly upstream of the switch PIO input port.
- Synchronises raw, asynchronous slide-switch/button levels into the clk domain and debounces each bit independently.
- Drives the debounced levels onto the PIO in_port, so software reads stable values.
- Also emits per-bit single-cycle rise/fall pulses for edge-capture or interrupt logic.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a level change is accepted (1 ms at 50 MHz); legal range 1..2^CNT_WIDTH.
- CNT_WIDTH, 16, width of each per-bit stability counter.
- INIT_VAL, 0 (WIDTH bits), reset value of the debounced outputs and of both synchroniser stages.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- sw_raw  input  WIDTH  raw switch levels, asynchronous to clk.
- sw_clean  output  WIDTH  debounced levels, registered; connects to PIO in_port.
- rise_pulse  output  WIDTH  per-bit one-cycle pulse when sw_clean[i] goes 0->1.
- fall_pulse  output  WIDTH  per-bit one-cycle pulse when sw_clean[i] goes 1->0.
- any_change  output  1  registered OR of (rise_pulse | fall_pulse) for the same cycle.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state is reset asynchronously.
- Reset values:
  - sync1 = sync2 = INIT_VAL.
  - sw_clean = INIT_VAL.
  - All counters = 0.
  - rise_pulse = fall_pulse = 0; any_change = 0.
- Synchroniser: two flops per bit (sync1 <= sw_raw; sync2 <= sync1). No logic between the stages. sync2 is the only input to the debounce logic.
- Per-bit debounce, evaluated every clk edge for each bit i:
  - If sync2[i] == sw_clean[i]: cnt[i] <= 0; no pulse.
  - If sync2[i] != sw_clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1; no pulse.
  - If sync2[i] != sw_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1:
    - sw_clean[i] <= sync2[i]; cnt[i] <= 0.
    - rise_pulse[i] <= sync2[i]; fall_pulse[i] <= ~sync2[i].
- Pulses are registered and high for exactly one cycle, concurrent with the first cycle in which the new sw_clean value is visible. They are cleared on the next edge unless a new acceptance occurs.
- any_change is computed from the same next-state pulse terms, so it is coincident with the pulses.
- Latency: a clean step on sw_raw[i] that is stable before edge k appears on sw_clean[i] after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles.
- Glitch rejection: any return of sync2[i] to sw_clean[i] before acceptance zeroes cnt[i]. A bounce must restart the full count.
- DEBOUNCE_CYCLES = 1: the change is accepted on the first differing cycle (pure 2-flop sync plus one register).
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. CNT_WIDTH must hold DEBOUNCE_CYCLES-1; this is checked by an elaboration-time assertion in simulation.
- Bits are fully independent. Simultaneous acceptances on several bits give multiple pulse bits in the same cycle and a single any_change cycle.
- Reset mid-count: all counts are discarded and outputs return to INIT_VAL immediately (asynchronously). If sw_raw differs from INIT_VAL after release, it is accepted after DEBOUNCE_CYCLES+2 cycles with the corresponding pulse.
- No combinational path from sw_raw to any output.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=8, INIT_VAL=0 unless stated):
- Reset with sw_raw=8'h00, then step sw_raw to 8'h01 held 20 cycles -> sw_clean=8'h01 exactly 6 cycles after the step edge; rise_pulse=8'h01 and any_change=1 for exactly that one cycle; fall_pulse stays 0.
- From sw_clean=8'h01, pulse sw_raw[0] low for 3 cycles, then high -> sw_clean stays 8'h01, no pulses. Repeat with a low of 4+ cycles -> sw_clean=8'h00 and fall_pulse=8'h01 once.
- Bouncy edge: sw_raw[3] toggles 1,0,1,0 on successive cycles, then holds 1 -> exactly one rise_pulse[3], 6 cycles after the final transition; no intermediate changes on sw_clean.
- Simultaneous step of sw_raw from 8'h0F to 8'hF0 -> on the same cycle sw_clean=8'hF0, rise_pulse=8'hF0, fall_pulse=8'h0F, any_change=1 for one cycle.
- Assert reset_n while cnt is mid-count (2 cycles into an accepted change), release with sw_raw=8'hFF -> sw_clean=8'h00 during reset; sw_clean=8'hFF with rise_pulse=8'hFF 6 cycles after release.
- DEBOUNCE_CYCLES=1 build: step sw_raw 8'h00->8'hA5 -> sw_clean=8'hA5 3 cycles later with rise_pulse=8'hA5 for one cycle.

Source files
------------

// File: rtl/switch_debounce_sync.sv
`timescale 1ns/1ps
// Purpose: 2-flop synchroniser plus per-bit debounce for raw switch/button levels feeding the PIO in_port.
// Latency: a clean step stable before edge k is visible on sw_clean after edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running level conditioner, pulses are single-cycle and must be consumed when seen.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset; all state returns to INIT_VAL / zero
//   sw_raw     raw switch levels, asynchronous to clk
//   sw_clean   debounced, registered levels (to PIO in_port)
//   rise_pulse per-bit one-cycle pulse when sw_clean[i] goes 0->1
//   fall_pulse per-bit one-cycle pulse when sw_clean[i] goes 1->0
//   any_change registered OR of all rise/fall pulse bits, coincident with them
module switch_debounce_sync #(
    parameter int                WIDTH           = 8,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                CNT_WIDTH       = 16,
    parameter logic [WIDTH-1:0]  INIT_VAL        = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    // The counter must be able to hold DEBOUNCE_CYCLES-1 and the threshold
    // must be at least one cycle; anything else is a build error.
    if (DEBOUNCE_CYCLES < 1 ||
        64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_cfg
        $error("switch_debounce_sync: DEBOUNCE_CYCLES=%0d out of range for CNT_WIDTH=%0d",
               DEBOUNCE_CYCLES, CNT_WIDTH);
    end

    // Count value at which a still-differing input is accepted.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Synchroniser stages: kept as bare flop-to-flop so the metastability
    // settling window is not eaten by logic.
    logic [WIDTH-1:0]     sync1;
    logic [WIDTH-1:0]     sync2;

    logic [CNT_WIDTH-1:0] cnt     [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0]     clean_nxt;
    logic [WIDTH-1:0]     rise_nxt;
    logic [WIDTH-1:0]     fall_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= INIT_VAL;
            sync2 <= INIT_VAL;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce. Any cycle where the synchronised input agrees with
    // the accepted level zeroes the count, so a bounce restarts the full
    // stability window. Acceptance uses >= so a corrupted count can never
    // run past the threshold and wrap.
    always_comb begin
        cnt_nxt   = cnt;
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == sw_clean[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] >= CNT_MAX) begin
                cnt_nxt[i]   = '0;
                clean_nxt[i] = sync2[i];
                rise_nxt[i]  = sync2[i];
                fall_nxt[i]  = ~sync2[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            sw_clean   <= INIT_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            sw_clean   <= clean_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            // Built from the next-state pulse terms so it lines up with them.
            any_change <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_switch_debounce_sync.sv
`timescale 1ns/1ps
module tb_switch_debounce_sync;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic [7:0] sw_clean, rise_pulse, fall_pulse;
    logic       any_change;
    logic [7:0] sw_raw1 = 8'h00;
    logic [7:0] sw_clean1, rise_pulse1, fall_pulse1;
    logic       any_change1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    switch_debounce_sync #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16), .INIT_VAL(8'h00)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    switch_debounce_sync #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16), .INIT_VAL(8'h00)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw1),
        .sw_clean   (sw_clean1),
        .rise_pulse (rise_pulse1),
        .fall_pulse (fall_pulse1),
        .any_change (any_change1)
    );

    typedef struct {
        logic [7:0] raw;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } vec_t;

    vec_t tbl [64];
    int   n_vec = 0;

    task automatic add(input logic [7:0] raw, input logic [7:0] clean, input logic [7:0] rise,
                       input logic [7:0] fall, input logic any, input int n);
        for (int i = 0; i < n; i++) begin
            tbl[n_vec].raw   = raw;
            tbl[n_vec].clean = clean;
            tbl[n_vec].rise  = rise;
            tbl[n_vec].fall  = fall;
            tbl[n_vec].any   = any;
            n_vec++;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [7:0] c, input logic [7:0] r,
                        input logic [7:0] f, input logic a);
        chk($sformatf("%s.sw_clean", tag),   sw_clean,          c);
        chk($sformatf("%s.rise_pulse", tag), rise_pulse,        r);
        chk($sformatf("%s.fall_pulse", tag), fall_pulse,        f);
        chk($sformatf("%s.any_change", tag), {7'd0, any_change}, {7'd0, a});
    endtask

    task automatic chk4_d1(input string tag, input logic [7:0] c, input logic [7:0] r,
                           input logic [7:0] f, input logic a);
        chk($sformatf("%s.sw_clean", tag),   sw_clean1,          c);
        chk($sformatf("%s.rise_pulse", tag), rise_pulse1,        r);
        chk($sformatf("%s.fall_pulse", tag), fall_pulse1,        f);
        chk($sformatf("%s.any_change", tag), {7'd0, any_change1}, {7'd0, a});
    endtask

    initial begin
        // Each entry: raw applied just after an edge, outputs checked #1 after the next edge.
        // Step 00->01: accepted on the 6th edge after the step.
        add(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 5);
        add(8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 1);
        add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 2);
        // 3-cycle low glitch on bit 0: rejected.
        add(8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 3);
        add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 4);
        // Sustained low: accepted with a single fall pulse.
        add(8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 5);
        add(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2);
        // Bouncy rise on bit 3: 1,0,1,0 then hold 1; one pulse 6 edges after the final transition.
        add(8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        add(8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        add(8'h08, 8'h00, 8'h00, 8'h00, 1'b0, 5);
        add(8'h08, 8'h08, 8'h08, 8'h00, 1'b1, 1);
        add(8'h08, 8'h08, 8'h00, 8'h00, 1'b0, 1);
        // Move to 0F, then simultaneous step 0F->F0.
        add(8'h0F, 8'h08, 8'h00, 8'h00, 1'b0, 5);
        add(8'h0F, 8'h0F, 8'h07, 8'h00, 1'b1, 1);
        add(8'h0F, 8'h0F, 8'h00, 8'h00, 1'b0, 1);
        add(8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 5);
        add(8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1, 1);
        add(8'hF0, 8'hF0, 8'h00, 8'h00, 1'b0, 2);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk4("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        chk4_d1("reset_d1", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;

        for (int v = 0; v < n_vec; v++) begin
            sw_raw = tbl[v].raw;
            @(posedge clk);
            #1;
            chk4($sformatf("vec%0d", v), tbl[v].clean, tbl[v].rise, tbl[v].fall, tbl[v].any);
        end

        // Reset in the middle of a count (clean=F0, raw steps to FF).
        sw_raw = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        chk4("midrst_async", 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk4("midrst_held", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            if (e < 6)
                chk4($sformatf("postrst_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
            else if (e == 6)
                chk4("postrst_e6", 8'hFF, 8'hFF, 8'h00, 1'b1);
            else
                chk4("postrst_e7", 8'hFF, 8'h00, 8'h00, 1'b0);
        end

        // DEBOUNCE_CYCLES=1 build: accepted 3 edges after the step.
        sw_raw1 = 8'hA5;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e < 3)
                chk4_d1($sformatf("d1_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
            else if (e == 3)
                chk4_d1("d1_e3", 8'hA5, 8'hA5, 8'h00, 1'b1);
            else
                chk4_d1("d1_e4", 8'hA5, 8'h00, 8'h00, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
